// File: rtl/si570_cfg_pkg.sv
// si570_cfg_pkg: shared types and constants for the Si570 preset sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package si570_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FREEZE,
    REGS,
    UNFREEZE,
    NEWFREQ,
    SETTLE,
    DONE
  } state_t;

  // Si570 register map: RFREQ/HSDIV/N1 block starts at 7, control at 135, DCO freeze at 137
  localparam logic [7:0] REG_RFREQ_BASE = 8'd7;
  localparam logic [7:0] REG_CTRL       = 8'd135;
  localparam logic [7:0] REG_FREEZE     = 8'd137;

  localparam logic [7:0] FREEZE_ON   = 8'h10;
  localparam logic [7:0] FREEZE_OFF  = 8'h00;
  localparam logic [7:0] NEWFREQ_VAL = 8'h40;

  // Register 7..12 images per preset, byte for reg 7 in bits [47:40]; index 0 is the rightmost entry
  localparam logic [3:0][47:0] PRESET_TABLE = {
    48'hA2E0_4A5B_9C33,
    48'h2160_C2B4_F7A1,
    48'h07C3_0276_3EF2,
    48'h01C2_BC01_1EB8
  };

endpackage

// File: rtl/si570_preset_rom.sv
// si570_preset_rom: maps a 2-bit preset index to its 48-bit register image.
// Latency: combinational.
// Backpressure: none.
module si570_preset_rom
  import si570_cfg_pkg::*;
(
  input  logic [1:0]  iSel,
  output logic [47:0] oPreset
);

  assign oPreset = PRESET_TABLE[iSel];

endmodule

// File: rtl/si570_cfg_sequencer.sv
// si570_cfg_sequencer: arbitrates button/host preset requests and programs the Si570 with 9 I2C writes.
// Latency: grant 1 cycle after request; each write command rises 1 cycle after its state is entered.
// Backpressure: a write is held until iI2C_done; button requests are latched while busy, host requests wait.
// Build option: SI570_CFG_SETTLE_EN adds a SETTLE_CYCLES wait after the NewFreq write.
module si570_cfg_sequencer
  import si570_cfg_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 20000,
  parameter int unsigned RETRY_MAX     = 3
) (
  input  logic       iCLK,
  input  logic       iRST_n,
  input  logic       iBtn_req,
  input  logic [1:0] iBtn_sel,
  input  logic       iHost_req,
  input  logic [1:0] iHost_sel,
  output logic       oHost_ack,
  output logic       oI2C_go,
  output logic [7:0] oI2C_reg,
  output logic [7:0] oI2C_data,
  input  logic       iI2C_done,
  input  logic       iI2C_err,
  output logic       oBusy,
  output logic       oError,
  output logic [1:0] oCur_sel
);

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  state_t          state;
  logic [1:0]      jobSel;
  logic [1:0]      btnSel;
  logic            btnPend;
  logic            jobHost;
  logic            lastHost;
  logic [2:0]      regIdx;
  logic [RW-1:0]   retryCnt;
  logic [47:0]     preset;
  logic [5:0][7:0] presetBytes;
  logic [7:0]      wrReg;
  logic [7:0]      wrData;
  logic            grantHost;
  logic            grantBtn;

`ifdef SI570_CFG_SETTLE_EN
  logic [31:0]     settleCnt;
`else
  logic            unusedSettle;
  assign unusedSettle = ^SETTLE_CYCLES;
`endif

  si570_preset_rom u_rom (
    .iSel    (jobSel),
    .oPreset (preset)
  );

  assign presetBytes = preset;
  assign oBusy       = (state != IDLE);

  // Round-robin: whoever was not served last wins a tie; lastHost=0 favours the host
  assign grantHost = (state == IDLE) && iHost_req && (!btnPend || !lastHost);
  assign grantBtn  = (state == IDLE) && btnPend && (!iHost_req || lastHost);

  // Register/data of the write belonging to the current state
  always_comb begin
    wrReg  = REG_FREEZE;
    wrData = FREEZE_ON;
    case (state)
      REGS: begin
        wrReg  = REG_RFREQ_BASE + {5'd0, regIdx};
        wrData = presetBytes[3'd5 - regIdx];
      end
      UNFREEZE: wrData = FREEZE_OFF;
      NEWFREQ: begin
        wrReg  = REG_CTRL;
        wrData = NEWFREQ_VAL;
      end
      default: ;
    endcase
  end

  // Sequencer: request latching, arbitration, write issue/retry, settle and completion
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state     <= IDLE;
      jobSel    <= 2'd0;
      btnSel    <= 2'd0;
      btnPend   <= 1'b0;
      jobHost   <= 1'b0;
      lastHost  <= 1'b0;
      regIdx    <= 3'd0;
      retryCnt  <= '0;
      oHost_ack <= 1'b0;
      oI2C_go   <= 1'b0;
      oI2C_reg  <= 8'd0;
      oI2C_data <= 8'd0;
      oError    <= 1'b0;
      oCur_sel  <= 2'd0;
`ifdef SI570_CFG_SETTLE_EN
      settleCnt <= 32'd0;
`endif
    end else begin
      oHost_ack <= 1'b0;

      // A new pulse always wins over clearing, so no button request is ever lost
      if (iBtn_req) begin
        btnPend <= 1'b1;
        btnSel  <= iBtn_sel;
      end else if (grantBtn) begin
        btnPend <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (grantHost || grantBtn) begin
            state    <= FREEZE;
            oError   <= 1'b0;
            jobHost  <= grantHost;
            lastHost <= grantHost;
            jobSel   <= grantHost ? iHost_sel : btnSel;
            regIdx   <= 3'd0;
            retryCnt <= '0;
          end
        end

        FREEZE, REGS, UNFREEZE, NEWFREQ: begin
          if (!oI2C_go) begin
            oI2C_go   <= 1'b1;
            oI2C_reg  <= wrReg;
            oI2C_data <= wrData;
          end else if (iI2C_done) begin
            oI2C_go <= 1'b0;
            if (iI2C_err) begin
              if (retryCnt == RW'(RETRY_MAX)) begin
                state     <= DONE;
                oError    <= 1'b1;
                oHost_ack <= jobHost;
                retryCnt  <= '0;
              end else begin
                retryCnt <= retryCnt + 1'b1;
              end
            end else begin
              retryCnt <= '0;
              case (state)
                FREEZE: state <= REGS;
                REGS: begin
                  if (regIdx == 3'd5) begin
                    regIdx <= 3'd0;
                    state  <= UNFREEZE;
                  end else begin
                    regIdx <= regIdx + 3'd1;
                  end
                end
                UNFREEZE: state <= NEWFREQ;
                default: begin
`ifdef SI570_CFG_SETTLE_EN
                  state     <= SETTLE;
                  settleCnt <= 32'd0;
`else
                  state     <= DONE;
                  oHost_ack <= jobHost;
`endif
                end
              endcase
            end
          end
        end

`ifdef SI570_CFG_SETTLE_EN
        SETTLE: begin
          if (settleCnt + 32'd1 >= SETTLE_CYCLES) begin
            state     <= DONE;
            oHost_ack <= jobHost;
          end else begin
            settleCnt <= settleCnt + 32'd1;
          end
        end
`endif

        DONE: begin
          state <= IDLE;
          if (!oError) oCur_sel <= jobSel;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/si570_cfg_sequencer.md
SI570_CFG_SEQUENCER -- requirements
Module: si570_cfg_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 20000, cycles waited after NewFreq before completion.
REQ-002 SHALL have parameter RETRY_MAX, default 3, retries allowed per failed I2C write.
REQ-003 iCLK  in  1  clock; all logic on its rising edge.
REQ-004 iRST_n  in  1  reset, asynchronous, active-low.
REQ-005 iBtn_req  in  1  single-cycle request pulse from the button debouncer.
REQ-006 iBtn_sel  in  2  preset index, sampled with iBtn_req.
REQ-007 iHost_req  in  1  level request, held until oHost_ack.
REQ-008 iHost_sel  in  2  preset index, stable while iHost_req=1.
REQ-009 oHost_ack  out  1  one-cycle pulse: host job finished, success or abort.
REQ-010 oI2C_go  out  1  write command valid; held until iI2C_done.
REQ-011 oI2C_reg  out  8  Si570 register address, valid with oI2C_go.
REQ-012 oI2C_data  out  8  write data, valid with oI2C_go.
REQ-013 iI2C_done  in  1  one-cycle write-completion pulse.
REQ-014 iI2C_err  in  1  NACK flag, qualified by iI2C_done.
REQ-015 oBusy  out  1  high whenever state is not IDLE.
REQ-016 oError  out  1  sticky abort flag.
REQ-017 oCur_sel  out  2  last successfully programmed preset.

Function
REQ-018 States SHALL be IDLE, FREEZE, REGS, UNFREEZE, NEWFREQ, SETTLE, DONE.
REQ-019 A button pulse SHALL set a pending flag and latch iBtn_sel; a new pulse while pending SHALL overwrite the latched sel.
REQ-020 In IDLE with one requester pending, that requester SHALL be granted the next cycle; with both pending, the requester not served last SHALL win (round-robin, host after reset).
REQ-021 On grant: oError cleared, button pending cleared (if button), sel latched, state to FREEZE.
REQ-022 Write order SHALL be reg 137=0x10; regs 7..12 = preset bytes 0..5 (MSB first); reg 137=0x00; reg 135=0x40 (9 writes total).
REQ-023 oI2C_go SHALL rise the cycle after a write state is entered and fall the cycle after iI2C_done; reg/data SHALL be stable while go=1.
REQ-024 iI2C_done while oI2C_go=0 SHALL be ignored.
REQ-025 iI2C_done with iI2C_err=1 SHALL reissue the same write; after RETRY_MAX retries also fail, SHALL go to DONE with oError=1 and oCur_sel unchanged.
REQ-026 The retry counter SHALL clear on every successful write.
REQ-027 After NEWFREQ success SHALL count SETTLE_CYCLES in SETTLE, then DONE.
REQ-028 DONE SHALL last one cycle: update oCur_sel on success, pulse oHost_ack if the job was host's, return to IDLE.
REQ-029 Button pulses during a job SHALL be latched, never dropped; iHost_req during a job waits.

Reset
REQ-030 Reset SHALL force IDLE, all outputs 0, oCur_sel=0, pending/retry/settle counters 0, round-robin to host-first, mid-operation included.

Configuration
REQ-031 With SI570_CFG_SETTLE_EN defined, SETTLE SHALL wait SETTLE_CYCLES; undefined, SETTLE SHALL be omitted and NEWFREQ success SHALL go directly to DONE.

Structure
REQ-032 Package si570_cfg_pkg SHALL hold the state enum, register addresses (7, 135, 137), the values 0x10/0x00/0x40, and the 4x48-bit preset table.
REQ-033 Sub-module si570_preset_rom SHALL be a combinational 2-bit-to-48-bit lookup of the package table.

Verification
REQ-034 Host req sel=1, no errors -> 9 writes per REQ-022 using preset 1; oHost_ack pulses once; oCur_sel=1; oError=0.
REQ-035 iI2C_err=1 on the first reg 9 write only -> reg 9 reissued once with the same data; job completes; oError=0.
REQ-036 iI2C_err=1 on all 4 attempts of reg 137 freeze -> abort; oError=1; oHost_ack pulses; oCur_sel unchanged; no further writes.
REQ-037 Button pulse sel=2 and host req sel=3 in the same IDLE cycle after reset -> host served first, then button; final oCur_sel=2.
REQ-038 iRST_n low while oI2C_go=1 during reg 10 -> all outputs 0 immediately; a following host req restarts from reg 137.
REQ-039 Macro defined, SETTLE_CYCLES=5 -> oHost_ack 6 cycles after the NEWFREQ done; macro undefined -> 1 cycle after.
